// File: rtl/fc_argmax.sv
// rtl/fc_argmax.sv - argmax over the FC3 score buffer with a valid/ready result port
module fc_argmax #(
    parameter int NUM_CLASS  = 10,
    parameter int DATA_WID   = 16,
    parameter int ADDR_WID   = 8,
    parameter int BASE_ADDR  = 0,
    parameter int RD_LATENCY = 1,
    parameter int IDX_WID    = 4
) (
    input  logic                clk,
    input  logic                rstn,
    input  logic                start,
    output logic                busy,
    output logic                rd_en,
    output logic [ADDR_WID-1:0] rd_addr,
    input  logic [DATA_WID-1:0] rd_data,
    output logic                result_valid,
    input  logic                result_ready,
    output logic [IDX_WID-1:0]  class_idx,
    output logic [DATA_WID-1:0] max_val
);

    localparam int CNT_WID = $clog2(NUM_CLASS + 1);

    typedef enum logic [1:0] {
        IDLE,
        READ,
        DRAIN,
        OUT
    } state_t;

    state_t              state;
    state_t              state_nxt;
    logic [CNT_WID-1:0]  issue_cnt;
    logic [CNT_WID-1:0]  recv_cnt;
    logic [RD_LATENCY-1:0] tag;
    logic                sample_vld;
    logic                last_issue;
    logic                last_sample;

    // tag[RD_LATENCY-1] lines up with the read data of the read issued RD_LATENCY cycles ago
    assign sample_vld  = tag[RD_LATENCY-1];
    assign last_issue  = (issue_cnt == CNT_WID'(NUM_CLASS - 1));
    assign last_sample = sample_vld && (recv_cnt == CNT_WID'(NUM_CLASS - 1));

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:    if (start) state_nxt = READ;
            READ:    if (last_issue) state_nxt = DRAIN;
            DRAIN:   if (last_sample) state_nxt = OUT;
            OUT:     if (result_ready) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            busy         <= 1'b0;
            rd_en        <= 1'b0;
            rd_addr      <= '0;
            result_valid <= 1'b0;
            class_idx    <= '0;
            max_val      <= '0;
            issue_cnt    <= '0;
            recv_cnt     <= '0;
            tag          <= '0;
        end else begin
            // Status outputs follow the next state so they are registered yet cycle-aligned
            busy         <= (state_nxt != IDLE);
            rd_en        <= (state_nxt == READ);
            result_valid <= (state_nxt == OUT);
            tag          <= (tag << 1) | RD_LATENCY'(rd_en);

            if (state == IDLE && start) begin
                issue_cnt <= '0;
                recv_cnt  <= '0;
                rd_addr   <= ADDR_WID'(BASE_ADDR);
            end else if (state == READ) begin
                issue_cnt <= issue_cnt + 1'b1;
                if (!last_issue) begin
                    rd_addr <= rd_addr + 1'b1;
                end
            end

            // First sample loads unconditionally; later ones only on strictly greater, so ties keep the lower index
            if (sample_vld) begin
                recv_cnt <= recv_cnt + 1'b1;
                if (recv_cnt == '0 || $signed(rd_data) > $signed(max_val)) begin
                    max_val   <= rd_data;
                    class_idx <= IDX_WID'(recv_cnt);
                end
            end
        end
    end

endmodule

// File: tb/tb_fc_argmax.sv
// tb/tb_fc_argmax.sv - self-checking bench for fc_argmax against a behavioural argmax model
module tb_fc_argmax;

    logic        clk = 1'b0;
    logic        rstn = 1'b0;
    logic        start = 1'b0;
    logic        busy;
    logic        rd_en;
    logic [7:0]  rd_addr;
    logic [15:0] rd_data;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [3:0]  class_idx;
    logic [15:0] max_val;

    logic        start3 = 1'b0;
    logic        busy3;
    logic        rd_en3;
    logic [7:0]  rd_addr3;
    logic [15:0] rd_data3;
    logic        result_valid3;
    logic        result_ready3 = 1'b0;
    logic [3:0]  class_idx3;
    logic [15:0] max_val3;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    fc_argmax dut (
        .clk(clk), .rstn(rstn), .start(start), .busy(busy),
        .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
        .result_valid(result_valid), .result_ready(result_ready),
        .class_idx(class_idx), .max_val(max_val)
    );

    fc_argmax #(.RD_LATENCY(3), .BASE_ADDR('h40)) dut3 (
        .clk(clk), .rstn(rstn), .start(start3), .busy(busy3),
        .rd_en(rd_en3), .rd_addr(rd_addr3), .rd_data(rd_data3),
        .result_valid(result_valid3), .result_ready(result_ready3),
        .class_idx(class_idx3), .max_val(max_val3)
    );

    // Score buffer; data bus carries junk whenever no read is outstanding
    logic [15:0] mem [0:255];
    logic [15:0] p1, q0, q1, q2;
    always @(posedge clk) begin
        p1 <= rd_en ? mem[rd_addr] : 16'($urandom);
        q0 <= rd_en3 ? mem[rd_addr3] : 16'($urandom);
        q1 <= q0;
        q2 <= q1;
    end
    assign rd_data  = p1;
    assign rd_data3 = q2;

    task automatic ref_argmax(input int base, output int idx, output logic [15:0] val);
        int best;
        best = -100000;
        for (int i = 0; i < 10; i++)
            if (int'($signed(mem[base+i])) > best) best = int'($signed(mem[base+i]));
        idx = -1;
        for (int i = 9; i >= 0; i--)
            if (int'($signed(mem[base+i])) == best) idx = i;
        val = 16'(best);
    endtask

    int n_rd, first_rd, last_rd, addr_err, rv_cycle, n_rv, hs_cycle, n_hs, busy_fall, stable_err;
    logic busy_at0, busy_at1;
    logic [3:0]  got_idx;
    logic [15:0] got_val;

    task automatic run(input int hold, input int s1, input int s2, input int tail);
        n_rd = 0; first_rd = -1; last_rd = -1; addr_err = 0; rv_cycle = -1; n_rv = 0;
        hs_cycle = -1; n_hs = 0; busy_fall = -1; stable_err = 0;
        got_idx = 'x; got_val = 'x; busy_at1 = 1'bx;
        @(negedge clk);
        busy_at0 = busy;
        start = 1'b1;
        result_ready = 1'b0;
        @(posedge clk);
        for (int cyc = 1; cyc < 80; cyc++) begin
            @(negedge clk);
            start = (cyc == s1 || cyc == s2);
            if (cyc == 1) busy_at1 = busy;
            if (rd_en) begin
                n_rd++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
                if (rd_addr !== 8'(cyc - 1)) addr_err++;
            end
            result_ready = 1'b0;
            if (result_valid) begin
                n_rv++;
                if (rv_cycle < 0) begin
                    rv_cycle = cyc; got_idx = class_idx; got_val = max_val;
                end else if (class_idx !== got_idx || max_val !== got_val) begin
                    stable_err++;
                end
                if (cyc - rv_cycle >= hold) begin
                    result_ready = 1'b1; n_hs++; hs_cycle = cyc;
                end
            end
            if (hs_cycle >= 0 && cyc > hs_cycle && !busy && busy_fall < 0) busy_fall = cyc;
            if (hs_cycle >= 0 && cyc >= hs_cycle + tail) break;
            @(posedge clk);
        end
        start = 1'b0;
    endtask

    task automatic check_ref(input string name);
        int ridx;
        logic [15:0] rval;
        ref_argmax(0, ridx, rval);
        checks++; if (got_idx !== 4'(ridx)) begin errors++; $display("FAIL %s_idx: got %0d want %0d", name, got_idx, ridx); end
        checks++; if (got_val !== rval) begin errors++; $display("FAIL %s_val: got %h want %h", name, got_val, rval); end
    endtask

    task automatic test_reset;
        repeat (3) @(negedge clk);
        checks++; if ({busy, rd_en, rd_addr, result_valid, class_idx, max_val} !== '0) begin
            errors++; $display("FAIL reset_outputs: got %h want 0", {busy, rd_en, rd_addr, result_valid, class_idx, max_val}); end
        checks++; if ({busy3, rd_en3, rd_addr3, result_valid3, class_idx3, max_val3} !== '0) begin
            errors++; $display("FAIL reset_outputs_lat3: got %h want 0", {busy3, rd_en3, rd_addr3, result_valid3, class_idx3, max_val3}); end
        rstn = 1'b1;
    endtask

    task automatic test_ascending;
        for (int i = 0; i < 10; i++) mem[i] = 16'(i);
        run(0, -1, -1, 2);
        checks++; if (busy_at0 !== 1'b0) begin errors++; $display("FAIL asc_busy0: got %b want 0", busy_at0); end
        checks++; if (busy_at1 !== 1'b1) begin errors++; $display("FAIL asc_busy1: got %b want 1", busy_at1); end
        checks++; if (n_rd !== 10) begin errors++; $display("FAIL asc_rd_count: got %0d want 10", n_rd); end
        checks++; if (first_rd !== 1 || last_rd !== 10) begin errors++; $display("FAIL asc_rd_window: got %0d..%0d want 1..10", first_rd, last_rd); end
        checks++; if (addr_err !== 0) begin errors++; $display("FAIL asc_addr: got %0d bad want 0", addr_err); end
        checks++; if (rv_cycle !== 12) begin errors++; $display("FAIL asc_valid_cycle: got %0d want 12", rv_cycle); end
        checks++; if (n_rv !== 1) begin errors++; $display("FAIL asc_valid_len: got %0d want 1", n_rv); end
        checks++; if (got_idx !== 4'd9) begin errors++; $display("FAIL asc_idx: got %0d want 9", got_idx); end
        checks++; if (got_val !== 16'd9) begin errors++; $display("FAIL asc_val: got %h want 0009", got_val); end
        checks++; if (busy_fall !== 13) begin errors++; $display("FAIL asc_busy_fall: got %0d want 13", busy_fall); end
    endtask

    task automatic test_ties_and_negative;
        logic [15:0] neg [0:9];
        neg = '{16'hFFFD, 16'hFFFF, 16'hFFF9, 16'hFFFC, 16'hFFFB, 16'hFFFA, 16'hFFF8, 16'hFFF7, 16'hFFF6, 16'hFFFE};
        for (int i = 0; i < 10; i++) mem[i] = 16'h0005;
        run(0, -1, -1, 2);
        checks++; if (got_idx !== 4'd0 || got_val !== 16'h0005) begin errors++; $display("FAIL tie_low: got %0d/%h want 0/0005", got_idx, got_val); end
        for (int i = 0; i < 10; i++) mem[i] = neg[i];
        run(0, -1, -1, 2);
        checks++; if (got_idx !== 4'd1 || got_val !== 16'hFFFF) begin errors++; $display("FAIL negative: got %0d/%h want 1/ffff", got_idx, got_val); end
    endtask

    task automatic test_extremes_backpressure;
        for (int i = 0; i < 10; i++) mem[i] = 16'h8000;
        mem[4] = 16'h7FFF;
        run(6, -1, -1, 2);
        checks++; if (rv_cycle !== 12 || hs_cycle !== 18) begin errors++; $display("FAIL bp_timing: got valid %0d hs %0d want 12 18", rv_cycle, hs_cycle); end
        checks++; if (n_rv !== 7 || stable_err !== 0) begin errors++; $display("FAIL bp_stable: got %0d cycles %0d changes want 7 0", n_rv, stable_err); end
        checks++; if (got_idx !== 4'd4 || got_val !== 16'h7FFF) begin errors++; $display("FAIL bp_result: got %0d/%h want 4/7fff", got_idx, got_val); end
        checks++; if (busy_fall !== 19) begin errors++; $display("FAIL bp_busy_fall: got %0d want 19", busy_fall); end
    endtask

    task automatic test_ignored_start;
        for (int i = 0; i < 10; i++) mem[i] = 16'($urandom);
        run(0, 3, 12, 4);
        checks++; if (n_rd !== 10) begin errors++; $display("FAIL ign_rd_count: got %0d want 10", n_rd); end
        checks++; if (n_hs !== 1) begin errors++; $display("FAIL ign_handshakes: got %0d want 1", n_hs); end
        check_ref("ign");
    endtask

    task automatic test_back_to_back;
        for (int i = 0; i < 10; i++) mem[i] = 16'($urandom);
        run(0, -1, -1, 0);
        check_ref("b2b_first");
        for (int i = 0; i < 10; i++) mem[i] = 16'($urandom);
        run(0, -1, -1, 2);
        checks++; if (busy_at0 !== 1'b0 || busy_at1 !== 1'b1) begin errors++; $display("FAIL b2b_busy: got %b%b want 01", busy_at0, busy_at1); end
        checks++; if (rv_cycle !== 12) begin errors++; $display("FAIL b2b_valid_cycle: got %0d want 12", rv_cycle); end
        check_ref("b2b_second");
    endtask

    task automatic test_random;
        for (int t = 0; t < 8; t++) begin
            for (int i = 0; i < 10; i++)
                mem[i] = (t % 2 == 0) ? 16'($urandom) : 16'($urandom_range(0, 6)) - 16'd3;
            run(int'($urandom_range(0, 3)), -1, -1, 2);
            checks++; if (rv_cycle !== 12) begin errors++; $display("FAIL rnd%0d_valid_cycle: got %0d want 12", t, rv_cycle); end
            check_ref("rnd");
        end
    endtask

    task automatic test_reset_mid;
        for (int i = 0; i < 10; i++) mem[i] = 16'($urandom);
        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        for (int c = 1; c <= 5; c++) begin
            @(negedge clk);
            start = 1'b0;
        end
        checks++; if (rd_en !== 1'b1) begin errors++; $display("FAIL mid_reading: got %b want 1", rd_en); end
        rstn = 1'b0;
        #1;
        checks++; if ({busy, rd_en, rd_addr, result_valid, class_idx, max_val} !== '0) begin
            errors++; $display("FAIL mid_reset_outputs: got %h want 0", {busy, rd_en, rd_addr, result_valid, class_idx, max_val}); end
        @(negedge clk);
        rstn = 1'b1;
        for (int i = 0; i < 10; i++) mem[i] = 16'($urandom);
        run(0, -1, -1, 2);
        checks++; if (rv_cycle !== 12 || n_rd !== 10) begin errors++; $display("FAIL mid_rerun: got valid %0d reads %0d want 12 10", rv_cycle, n_rd); end
        check_ref("mid");
    endtask

    task automatic test_latency3;
        int n = 0, aerr = 0, rv = -1, ridx;
        logic [3:0]  idx3;
        logic [15:0] val3, rval;
        for (int i = 0; i < 10; i++) mem['h40+i] = 16'($urandom_range(0, 1000)) - 16'd500;
        mem['h49] = 16'h1000;
        ref_argmax('h40, ridx, rval);
        @(negedge clk);
        start3 = 1'b1;
        result_ready3 = 1'b1;
        @(posedge clk);
        for (int cyc = 1; cyc < 40; cyc++) begin
            @(negedge clk);
            start3 = 1'b0;
            if (rd_en3) begin
                n++;
                if (rd_addr3 !== 8'('h40 + cyc - 1)) aerr++;
            end
            if (result_valid3 && rv < 0) begin rv = cyc; idx3 = class_idx3; val3 = max_val3; end
            if (rv >= 0 && cyc >= rv + 2) break;
            @(posedge clk);
        end
        result_ready3 = 1'b0;
        checks++; if (n !== 10 || aerr !== 0) begin errors++; $display("FAIL lat3_reads: got %0d reads %0d bad want 10 0", n, aerr); end
        checks++; if (rv !== 14) begin errors++; $display("FAIL lat3_valid_cycle: got %0d want 14", rv); end
        checks++; if (idx3 !== 4'(ridx) || idx3 !== 4'd9) begin errors++; $display("FAIL lat3_idx: got %0d want 9", idx3); end
        checks++; if (val3 !== rval) begin errors++; $display("FAIL lat3_val: got %h want %h", val3, rval); end
    endtask

    initial begin
        test_reset;
        test_ascending;
        test_ties_and_negative;
        test_extremes_backpressure;
        test_ignored_start;
        test_back_to_back;
        test_random;
        test_reset_mid;
        test_latency3;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
